qqspi_arbiter: RTL
==================

Name: qqspi_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single qqspi PSRAM/flash controller.
- Port 0 is the instruction-fetch bus; port 1 is the data bus.
- Holds off all traffic for a programmable power-up interval, which covers the PSRAM tPU ≥150 µs.
- Then grants one master at a time, round-robin or fixed priority.
- Enforces the qqspi handshake: valid held until ready, then valid dropped, then wait for ready to fall before the next request.

Parameters:
- STARTUP_CYCLES, 15000: clk cycles after reset release before any request is forwarded. 0 means no hold-off.
- ROUND_ROBIN, 1: 1 selects alternating priority; 0 means port 0 always wins.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- m0_valid, input, 1: port 0 request.
- m0_addr, input, 23: port 0 word address.
- m0_wdata, input, 32: port 0 write data.
- m0_wstrb, input, 4: port 0 byte strobes; 0 means read.
- m0_ready, output, 1: port 0 one-cycle completion pulse.
- m0_rdata, output, 32: port 0 read data, valid when m0_ready is high.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: as port 0, for port 1.
- s_valid, output, 1: request to qqspi.
- s_addr, output, 23: address to qqspi.
- s_wdata, output, 32: write data to qqspi.
- s_wstrb, output, 4: byte strobes to qqspi.
- s_ready, input, 1: qqspi ready; stays high until s_valid falls.
- s_rdata, input, 32: qqspi read data.
- init_done, output, 1: power-up hold-off elapsed.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state STARTUP, startup counter 0, last_grant = 1 (so port 0 wins first).
- States: STARTUP, IDLE, BUSY, RELEASE.
- STARTUP:
  - Counter increments each cycle.
  - When counter == STARTUP_CYCLES: init_done <= 1 (sticky until reset), go to IDLE.
  - Master requests are ignored (not lost): masters keep mN_valid high.
- IDLE:
  - If no mN_valid, stay.
  - Otherwise pick the winner:
    - Both valid and ROUND_ROBIN=1: the port != last_grant.
    - Both valid and ROUND_ROBIN=0: port 0.
    - Only one valid: that port.
  - Latch the winner's addr/wdata/wstrb into s_addr/s_wdata/s_wstrb registers, set s_valid <= 1, record grant, go to BUSY.
  - s_valid therefore rises 1 cycle after mN_valid is sampled in IDLE.
- BUSY:
  - s_valid held at 1; s_addr/s_wdata/s_wstrb stable.
  - On s_ready == 1: mG_rdata <= s_rdata, mG_ready <= 1 for exactly one cycle, s_valid <= 0, last_grant <= grant, go to RELEASE.
- RELEASE:
  - s_valid held at 0.
  - When s_ready == 0, go to IDLE.
  - mN_valid is ignored in this state; a master that re-requests immediately is served from IDLE.
- Master rules:
  - mN_valid and its payload are held stable until mN_ready.
  - The master may drop or re-raise valid the cycle after mN_ready.
  - mN_rdata holds its last captured value between completions.
  - The non-granted port's ready is never asserted.
- Minimum turnaround per access is mN_valid → s_valid 1 cycle, plus the qqspi latency, plus 1 cycle to mN_ready, plus ≥1 RELEASE cycle.
- Simultaneous events:
  - The granted master dropping valid while BUSY is a protocol violation. The access still completes and the ready pulse is still issued.
  - A new request from the other port during BUSY/RELEASE waits and wins in the next IDLE.
- Starvation bound with ROUND_ROBIN=1: a waiting port is served within one other-port transaction.
- Reset mid-transaction: s_valid drops immediately (asynchronously) and no ready pulse is issued. The hold-off restarts, because qqspi shares resetn and the PSRAM is assumed unpowered-stable only after hold-off.
- Counter width is $clog2(STARTUP_CYCLES+1), minimum 1.
- No combinational path from any input to any output.

Decomposition:
- Package qqspi_pkg:
  - ADDR_W = 23, DATA_W = 32, STRB_W = 4.
  - arbiter state enum {STARTUP, IDLE, BUSY, RELEASE}.
- Sub-module qqspi_startup_timer: parameter STARTUP_CYCLES; ports clk, resetn, done (sticky).
- Grant logic, payload registers and FSM stay in the top module.

Test Plan:
- STARTUP_CYCLES=10, m0 read at 0x000100 asserted at reset release.
  - s_valid stays 0 for 10 cycles; init_done rises at cycle 10; s_valid rises at cycle 11 with s_addr=0x000100, s_wstrb=0.
- Single m1 write, wdata=0xDEADBEEF, wstrb=4'b0011; model asserts s_ready after 20 cycles.
  - m1_ready pulses exactly 1 cycle, 1 cycle after s_ready; s_valid is 0 the same cycle as m1_ready; m0_ready stays 0.
- m0 and m1 both continuously valid, ROUND_ROBIN=1, 6 transactions.
  - Grant order 0,1,0,1,0,1; each mN_rdata equals the model's per-address data.
- Same stimulus with ROUND_ROBIN=0.
  - All 6 grants go to port 0; port 1 is served only after m0_valid drops.
- Model holds s_ready high for 5 cycles after s_valid falls.
  - No new s_valid until s_ready == 0, then s_valid rises ≥1 cycle later.
- resetn pulled low mid-BUSY.
  - s_valid, mN_ready and init_done go to 0 without waiting for clk; after release the full hold-off repeats and the pending request completes normally.

Source files
------------

// File: rtl/qqspi_pkg.sv
// ----------------------------------------------------------------------------
// qqspi_pkg: shared widths and arbiter state encoding for the qqspi front end.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qqspi_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    IDLE    = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/qqspi_startup_timer.sv
// ----------------------------------------------------------------------------
// qqspi_startup_timer: sticky flag raised STARTUP_CYCLES clocks after reset.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qqspi_startup_timer
  import qqspi_pkg::*;
#(
  parameter int STARTUP_CYCLES = 15000
) (
  input  logic clk,
  input  logic resetn,
  output logic done
);

  localparam int CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  // Counter freezes once done so it can never wrap and re-trigger.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (cnt_q == CNT_LAST) begin
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/qqspi_arbiter.sv
// ----------------------------------------------------------------------------
// qqspi_arbiter: two-master arbiter/sequencer with power-up hold-off for qqspi.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qqspi_arbiter
  import qqspi_pkg::*;
#(
  parameter int STARTUP_CYCLES = 15000,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              init_done
);

  arb_state_e        state_q, state_d;
  logic              timer_done;
  logic              req_any, win, both_pick, can_grant;
  logic              grant_q, grant_d, last_grant_q, last_grant_d;
  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;
  logic              m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  qqspi_startup_timer #(
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .done  (timer_done)
  );

  if (ROUND_ROBIN != 0) begin : g_rr
    assign both_pick = ~last_grant_q;
  end else begin : g_fixed
    assign both_pick = 1'b0;
  end

  assign req_any = m0_valid | m1_valid;
  assign win     = (m0_valid && m1_valid) ? both_pick : m1_valid;
  // The cycle the timer expires already behaves as IDLE, so the first grant
  // lands one clock after init_done rises.
  assign can_grant = (state_q == IDLE) || ((state_q == STARTUP) && timer_done);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STARTUP: if (timer_done) state_d = req_any ? BUSY : IDLE;
      IDLE:    if (req_any)    state_d = BUSY;
      BUSY:    if (s_ready)    state_d = RELEASE;
      RELEASE: if (!s_ready)   state_d = IDLE;
      default:                 state_d = STARTUP;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_valid_d    = s_valid_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    if (can_grant && req_any) begin
      grant_d   = win;
      s_valid_d = 1'b1;
      s_addr_d  = win ? m1_addr  : m0_addr;
      s_wdata_d = win ? m1_wdata : m0_wdata;
      s_wstrb_d = win ? m1_wstrb : m0_wstrb;
    end
    if ((state_q == BUSY) && s_ready) begin
      s_valid_d    = 1'b0;
      last_grant_d = grant_q;
      if (grant_q) begin
        m1_ready_d = 1'b1;
        m1_rdata_d = s_rdata;
      end else begin
        m0_ready_d = 1'b1;
        m0_rdata_d = s_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_valid_q    <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_valid_q    <= s_valid_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign s_valid   = s_valid_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign init_done = timer_done;

endmodule

`default_nettype wire
